// File: rtl/mac_result_writer_if.sv
// Capture-side bundle between the shared MAC bank (master) and a result writer (slave).
// Carries the capture handshake, packed lane accumulators, biases and the RAM base address.
interface mac_result_writer_if #(
  parameter int LANES  = 10,
  parameter int ACC_W  = 23,
  parameter int BIAS_W = 16,
  parameter int ADDR_W = 7
);
  logic                    cap_valid;
  logic                    cap_ready;
  logic [LANES*ACC_W-1:0]  mac_in;
  logic [LANES*BIAS_W-1:0] bias_in;
  logic [ADDR_W-1:0]       base_addr;

  modport master (
    output cap_valid,
    output mac_in,
    output bias_in,
    output base_addr,
    input  cap_ready
  );

  modport slave (
    input  cap_valid,
    input  mac_in,
    input  bias_in,
    input  base_addr,
    output cap_ready
  );
endinterface

// File: rtl/mac_result_writer.sv
// Captures one layer's lane accumulators, then streams bias-add / round / ReLU / saturate
// results into the next layer's feature RAM, one lane per cycle.
module mac_result_writer #(
  parameter int LANES  = 10,
  parameter int ACC_W  = 23,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 7,
  parameter int RELU   = 1,
  parameter int ADDR_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  mac_result_writer_if.slave cap,
  output logic               out_we,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [OUT_W-1:0]   out_wdata,
  output logic               busy,
  output logic               done,
  output logic [7:0]         sat_cnt
);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int S1_W  = ACC_W + 1;
  localparam int WIDE  = S1_W + OUT_W;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(LANES - 1);
  localparam logic signed [S1_W-1:0] ROUND    = S1_W'(1) << (SHIFT - 1);
  localparam logic signed [WIDE-1:0] OUT_MAX  = {{(WIDE-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WIDE-1:0] OUT_MIN  = {{(WIDE-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

  state_t state, state_nxt;
  logic   capture, issue, ready_int;

  logic [LANES*ACC_W-1:0]  mac_q;
  logic [LANES*BIAS_W-1:0] bias_q;
  logic [ADDR_W-1:0]       base_q;
  logic [IDX_W-1:0]        idx;

  logic                    s1_valid;
  logic signed [S1_W-1:0]  s1_sum;
  logic [IDX_W-1:0]        s1_lane;

  logic signed [ACC_W-1:0]  acc_k;
  logic signed [BIAS_W-1:0] bias_k;
  logic signed [S1_W-1:0]   s1_next;
  logic signed [S1_W-1:0]   shifted;
  logic signed [WIDE-1:0]   s2_wide;
  logic [OUT_W-1:0]         s2_data;
  logic                     s2_sat;

  assign cap.cap_ready = ready_int;

  // FLUSH leaves once stage 1 is empty: stage 2 drains on that same edge.
  always_comb begin
    state_nxt = state;
    ready_int = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    capture   = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        ready_int = 1'b1;
        busy      = 1'b0;
        if (cap.cap_valid) begin
          capture   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (idx == LAST_IDX) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (!s1_valid) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_k   = mac_q[idx*ACC_W +: ACC_W];
    bias_k  = bias_q[idx*BIAS_W +: BIAS_W];
    s1_next = S1_W'(acc_k) + S1_W'(bias_k) + ROUND;
  end

  // Saturation is judged after ReLU, so a ReLU clamp never counts as a clip.
  always_comb begin
    shifted = s1_sum >>> SHIFT;
    s2_wide = WIDE'(shifted);
    if (RELU != 0 && s2_wide[WIDE-1]) s2_wide = '0;
    s2_sat  = 1'b0;
    s2_data = s2_wide[OUT_W-1:0];
    if (s2_wide > OUT_MAX) begin
      s2_sat  = 1'b1;
      s2_data = OUT_MAX[OUT_W-1:0];
    end else if (s2_wide < OUT_MIN) begin
      s2_sat  = 1'b1;
      s2_data = OUT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mac_q  <= cap.mac_in;
      bias_q <= cap.bias_in;
      base_q <= cap.base_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_lane   <= '0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      out_wdata <= '0;
      sat_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (capture)    idx <= '0;
      else if (issue) idx <= idx + IDX_W'(1);

      s1_valid <= issue;
      if (issue) begin
        s1_sum  <= s1_next;
        s1_lane <= idx;
      end

      out_we <= s1_valid;
      if (s1_valid) begin
        out_addr  <= base_q + ADDR_W'(s1_lane);
        out_wdata <= s2_data;
      end

      if (capture)                                       sat_cnt <= '0;
      else if (s1_valid && s2_sat && sat_cnt != 8'hFF)   sat_cnt <= sat_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_mac_result_writer.sv
// Scoreboard bench for mac_result_writer: expected writes are queued at each capture
// handshake and matched against out_we cycles, addresses, data, done timing and sat_cnt.
module tb_mac_result_writer;
  localparam int LANES  = 10;
  localparam int ACC_W  = 23;
  localparam int BIAS_W = 16;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 7;
  localparam int RELU   = 1;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              out_we, busy, done;
  logic [ADDR_W-1:0] out_addr;
  logic [OUT_W-1:0]  out_wdata;
  logic [7:0]        sat_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_cap = -1;
  int n_caps   = 0;

  typedef struct {logic [ADDR_W-1:0] addr; logic [OUT_W-1:0] data; int cyc;} wr_t;
  typedef struct {int cyc; int sat;} done_t;
  wr_t   wq[$];
  done_t dq[$];

  mac_result_writer_if #(.LANES(LANES), .ACC_W(ACC_W), .BIAS_W(BIAS_W), .ADDR_W(ADDR_W)) cap_if ();

  mac_result_writer #(
    .LANES(LANES), .ACC_W(ACC_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W),
    .SHIFT(SHIFT), .RELU(RELU), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cap(cap_if),
    .out_we(out_we), .out_addr(out_addr), .out_wdata(out_wdata),
    .busy(busy), .done(done), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference arithmetic done in 64-bit integers, independent of the RTL widths.
  function automatic void model(input logic [ACC_W-1:0] a, input logic [BIAS_W-1:0] b,
                                output logic [OUT_W-1:0] d, output bit sat);
    longint s, r, mx, mn;
    mx = (longint'(1) << (OUT_W - 1)) - 1;
    mn = -mx - 1;
    s  = longint'($signed(a)) + longint'($signed(b)) + (longint'(1) << (SHIFT - 1));
    r  = s >>> SHIFT;
    if (RELU != 0 && r < 0) r = 0;
    sat = 1'b0;
    if (r > mx) begin r = mx; sat = 1'b1; end
    else if (r < mn) begin r = mn; sat = 1'b1; end
    d = r[OUT_W-1:0];
  endfunction

  always @(negedge clk) begin
    wr_t   e;
    done_t de;
    if (out_we) begin
      if (wq.size() == 0) checkOutput("unexp_we", {31'd0, out_we}, 32'd0);
      else begin
        e = wq.pop_front();
        checkOutput("wr_cycle", cyc, e.cyc);
        checkOutput("wr_addr", {25'd0, out_addr}, {25'd0, e.addr});
        checkOutput("wr_data", {16'd0, out_wdata}, {16'd0, e.data});
      end
    end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
      checkOutput("miss_we", {31'd0, out_we}, 32'd1);
      void'(wq.pop_front());
    end
    if (done) begin
      if (dq.size() == 0) checkOutput("unexp_done", {31'd0, done}, 32'd0);
      else begin
        de = dq.pop_front();
        checkOutput("done_cycle", cyc, de.cyc);
        checkOutput("sat_cnt", {24'd0, sat_cnt}, de.sat);
        checkOutput("done_busy", {31'd0, busy}, 32'd1);
      end
    end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
      checkOutput("miss_done", {31'd0, done}, 32'd1);
      void'(dq.pop_front());
    end
    if (busy) checkOutput("rdy_busy", {31'd0, cap_if.cap_ready}, 32'd0);
    if (cyc == last_cap) begin
      checkOutput("cap_busy", {31'd0, busy}, 32'd1);
      checkOutput("cap_satclr", {24'd0, sat_cnt}, 32'd0);
    end
    if (!rst_n) begin
      wq.delete();
      dq.delete();
      last_cap = -1;
    end else if (cap_if.cap_valid && cap_if.cap_ready) begin
      int t, s;
      logic [OUT_W-1:0] d;
      bit sat;
      t = cyc + 1;
      s = 0;
      for (int k = 0; k < LANES; k++) begin
        model(cap_if.mac_in[k*ACC_W +: ACC_W], cap_if.bias_in[k*BIAS_W +: BIAS_W], d, sat);
        wq.push_back('{addr: cap_if.base_addr + ADDR_W'(k), data: d, cyc: t + 2 + k});
        if (sat && s < 255) s++;
      end
      dq.push_back('{cyc: t + LANES + 2, sat: s});
      last_cap = t;
      n_caps++;
    end
  end

  task automatic applyStimulus(input logic [LANES*ACC_W-1:0] m, input logic [LANES*BIAS_W-1:0] b,
                               input logic [ADDR_W-1:0] base, input bit hold);
    bit got = 1'b0;
    @(posedge clk); #1;
    cap_if.mac_in    = m;
    cap_if.bias_in   = b;
    cap_if.base_addr = base;
    cap_if.cap_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cap_if.cap_ready) got = 1'b1;
    end
    if (!got) checkOutput("cap_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!hold) cap_if.cap_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic randJob(output logic [LANES*ACC_W-1:0] m, output logic [LANES*BIAS_W-1:0] b);
    for (int k = 0; k < LANES; k++) begin
      m[k*ACC_W +: ACC_W]   = ACC_W'($urandom);
      b[k*BIAS_W +: BIAS_W] = BIAS_W'($urandom);
    end
  endtask

  logic [LANES*ACC_W-1:0]  m, m2;
  logic [LANES*BIAS_W-1:0] b, b2;
  int  t1;
  bit  seen;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cap_if.cap_valid = 1'b1;
    cap_if.mac_in    = '1;
    cap_if.bias_in   = '0;
    cap_if.base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'd0, cap_if.cap_ready}, 32'd1);
    checkOutput("rst_we", {31'd0, out_we}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_addr", {25'd0, out_addr}, 32'd0);
    checkOutput("rst_wdata", {16'd0, out_wdata}, 32'd0);
    checkOutput("rst_sat", {24'd0, sat_cnt}, 32'd0);
    cap_if.cap_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("no_cap_in_rst", {31'd0, busy}, 32'd0);

    // Basic job: lane0 rounds 1092/128 to 8, lane k gives k.
    for (int k = 0; k < LANES; k++) begin
      m[k*ACC_W +: ACC_W]   = (k == 0) ? ACC_W'(1000) : ACC_W'(k * 128);
      b[k*BIAS_W +: BIAS_W] = (k == 0) ? BIAS_W'(28) : '0;
    end
    applyStimulus(m, b, 7'h20, 1'b0);
    waitDone("done_timeout_j1");
    checkOutput("j1_last_data", {16'd0, out_wdata}, 32'd9);
    checkOutput("j1_last_addr", {25'd0, out_addr}, 32'h29);

    // Saturation, ReLU and rounding corners.
    m = '0; b = '0;
    m[0*ACC_W +: ACC_W] = ACC_W'(4194303);  b[0*BIAS_W +: BIAS_W] = BIAS_W'(32767);
    m[1*ACC_W +: ACC_W] = ACC_W'(-4194304); b[1*BIAS_W +: BIAS_W] = BIAS_W'(-32768);
    m[2*ACC_W +: ACC_W] = ACC_W'(-500);
    m[3*ACC_W +: ACC_W] = ACC_W'(-64);
    m[4*ACC_W +: ACC_W] = ACC_W'(63);
    m[5*ACC_W +: ACC_W] = ACC_W'(64);
    m[6*ACC_W +: ACC_W] = ACC_W'(4194112);
    m[7*ACC_W +: ACC_W] = ACC_W'(4194240);
    m[8*ACC_W +: ACC_W] = ACC_W'(-1);
    m[9*ACC_W +: ACC_W] = ACC_W'(1000000); b[9*BIAS_W +: BIAS_W] = BIAS_W'(-1000);
    applyStimulus(m, b, 7'h50, 1'b0);
    waitDone("done_timeout_j2");
    checkOutput("j2_satcnt", {24'd0, sat_cnt}, 32'd2);
    checkOutput("j2_last_data", {16'd0, out_wdata}, 32'd7805);

    // Address wrap.
    randJob(m2, b2);
    applyStimulus(m2, b2, 7'h7E, 1'b0);
    waitDone("done_timeout_wrap");
    checkOutput("wrap_last_addr", {25'd0, out_addr}, 32'h07);

    // Back-to-back with cap_valid held: second capture lands two edges after done.
    applyStimulus(m, b, 7'h00, 1'b1);
    t1 = last_cap;
    randJob(m2, b2);
    cap_if.mac_in  = m2;
    cap_if.bias_in = b2;
    for (int i = 0; i < 100 && n_caps < 5; i++) begin
      @(posedge clk); #1;
    end
    cap_if.cap_valid = 1'b0;
    checkOutput("b2b_ncap", n_caps, 32'd5);
    checkOutput("b2b_cap_cycle", last_cap, t1 + LANES + 4);
    waitDone("done_timeout_b2b");

    // Reset in the middle of a job.
    randJob(m2, b2);
    applyStimulus(m2, b2, 7'h30, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_we", {31'd0, out_we}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready", {31'd0, cap_if.cap_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || out_we) seen = 1'b1;
    end
    checkOutput("midrst_quiet", {31'd0, seen}, 32'd0);
    randJob(m2, b2);
    applyStimulus(m2, b2, 7'h10, 1'b0);
    waitDone("done_timeout_post_rst");

    repeat (5) @(posedge clk);
    #1;
    checkOutput("wq_empty", wq.size(), 32'd0);
    checkOutput("dq_empty", dq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
